// File: rtl/alu4_pkg.sv
// Shared definitions for the small ALU/divider blocks.
//   state_t       : FSM state encoding used by div4_seq (IDLE=0, RUN=1, DONE=2)
//   DEFAULT_WIDTH : default operand width in bits
package alu4_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sub_borrow.sv
// Combinational ripple-borrow subtractor: difference = a - b.
// Ports:
//   a, b        : W-bit unsigned operands
//   difference  : W-bit result (modulo 2^W)
//   borrow_out  : high when a < b
module sub_borrow #(
    parameter int W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] difference,
    output logic         borrow_out
);

    logic [W:0] borrow_chain;

    assign borrow_chain[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_bit
            assign difference[gi]     = a[gi] ^ b[gi] ^ borrow_chain[gi];
            assign borrow_chain[gi+1] = (~a[gi] & b[gi]) |
                                        (~(a[gi] ^ b[gi]) & borrow_chain[gi]);
        end
    endgenerate

    assign borrow_out = borrow_chain[W];

endmodule

// File: rtl/div4_seq.sv
// Sequential restoring divider, one quotient bit per clock, MSB first.
// Ports:
//   clk          : clock, rising edge
//   rst_n        : asynchronous reset, active low
//   start        : begin a division (accepted in IDLE or DONE only)
//   dividend     : unsigned dividend, sampled when start is accepted
//   divisor      : unsigned divisor, sampled when start is accepted
//   busy         : high while the division is running (start ignored)
//   done         : one-cycle pulse, results valid
//   quotient     : unsigned quotient
//   remainder    : unsigned remainder
//   div_by_zero  : last accepted division had a zero divisor
// WIDTH must be at least 2.
module div4_seq
    import alu4_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] dvd_reg;   // dividend bits still to be shifted in, MSB first
    logic [WIDTH-1:0] dvs_reg;
    logic [WIDTH-1:0] rem_reg;   // working partial remainder
    logic [WIDTH-1:0] quo_reg;   // working quotient

    logic [WIDTH:0]   partial;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;
    logic             unused_diff_msb;

    // Shift the next dividend bit into the partial remainder, then trial-subtract.
    assign partial = {rem_reg, dvd_reg[WIDTH-1]};

    sub_borrow #(
        .W(WIDTH + 1)
    ) u_sub (
        .a          (partial),
        .b          ({1'b0, dvs_reg}),
        .difference (diff),
        .borrow_out (borrow)
    );

    // partial < 2*divisor, so a successful subtract always fits in WIDTH bits
    // and the difference MSB is zero.
    assign unused_diff_msb = diff[WIDTH];
    assign rem_step        = borrow ? partial[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_step        = {quo_reg[WIDTH-2:0], ~borrow};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            dvd_reg     <= '0;
            dvs_reg     <= '0;
            rem_reg     <= '0;
            quo_reg     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        dvd_reg <= dividend;
                        dvs_reg <= divisor;
                        rem_reg <= '0;
                        quo_reg <= '0;
                        cnt_reg <= '0;
                        if (divisor == '0) begin
                            // Nothing to iterate: report immediately.
                            state_reg   <= DONE;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state_reg   <= RUN;
                            busy        <= 1'b1;
                            done        <= 1'b0;
                            quotient    <= '0;
                            remainder   <= '0;
                            div_by_zero <= 1'b0;
                        end
                    end else begin
                        state_reg <= IDLE;
                        done      <= 1'b0;
                    end
                end

                RUN: begin
                    rem_reg <= rem_step;
                    quo_reg <= quo_step;
                    dvd_reg <= dvd_reg << 1;
                    if (cnt_reg == CW'(WIDTH - 1)) begin
                        // Last bit: publish the results directly from this step.
                        state_reg <= DONE;
                        cnt_reg   <= '0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= quo_step;
                        remainder <= rem_step;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div4_seq.sv
// Self-checking bench for div4_seq (WIDTH = 4): table-driven vectors, random
// operands against a / % model, and hand-written multi-cycle sequences.
// Results are checked by a scoreboard popped on every done pulse.
module tb_div4_seq;
    import alu4_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    div4_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;
        int           nbusy;
    } vec_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] q, input logic [W-1:0] r, input logic dbz);
        exp_t e;
        e.a = a; e.b = b; e.q = q; e.r = r; e.dbz = dbz;
        sb.push_back(e);
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.a = a;
        e.b = b;
        if (b == 0) begin
            e.q = 4'hF; e.r = a; e.dbz = 1'b1;
        end else begin
            e.q = a / b; e.r = a % b; e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check($sformatf("quotient %0d/%0d", e.a, e.b), int'(quotient), int'(e.q));
                check($sformatf("remainder %0d/%0d", e.a, e.b), int'(remainder), int'(e.r));
                check($sformatf("div_by_zero %0d/%0d", e.a, e.b), int'(div_by_zero), int'(e.dbz));
                $display("[TB] done %0d/%0d -> q=%0d r=%0d dbz=%0d", e.a, e.b,
                         quotient, remainder, div_by_zero);
            end
        end
    end

    // Counts cycles after the accepting edge until done; checks latency and busy time.
    task automatic wait_done(input int exp_lat, input int exp_busy);
        int cyc = 0;
        int nb = 0;
        bit seen = 1'b0;
        while (!seen && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (busy) nb++;
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            check("done_timeout", 0, 1);
        end else begin
            check("done_latency", cyc, exp_lat);
            check("busy_cycles", nb, exp_busy);
        end
    endtask

    task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] q, input logic [W-1:0] r, input logic dbz,
                           input int lat, input int nbusy);
        @(posedge clk); #1;
        start = 1'b1; dividend = a; divisor = b;
        push(a, b, q, r, dbz);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, nbusy);
        @(negedge clk);
        check("done_pulse_width", int'(done), 0);
        check("busy_after_done", int'(busy), 0);
        check("hold_quotient", int'(quotient), int'(q));
        check("hold_remainder", int'(remainder), int'(r));
        check("hold_div_by_zero", int'(div_by_zero), int'(dbz));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    vec_t tbl[10];

    initial begin
        tbl[0] = '{4'd13, 4'd4,  4'd3,  4'd1, 1'b0, 5, 4};
        tbl[1] = '{4'd15, 4'd1,  4'd15, 4'd0, 1'b0, 5, 4};
        tbl[2] = '{4'd3,  4'd7,  4'd0,  4'd3, 1'b0, 5, 4};
        tbl[3] = '{4'd15, 4'd15, 4'd1,  4'd0, 1'b0, 5, 4};
        tbl[4] = '{4'd9,  4'd0,  4'd15, 4'd9, 1'b1, 1, 0};
        tbl[5] = '{4'd0,  4'd5,  4'd0,  4'd0, 1'b0, 5, 4};
        tbl[6] = '{4'd12, 4'd5,  4'd2,  4'd2, 1'b0, 5, 4};
        tbl[7] = '{4'd15, 4'd2,  4'd7,  4'd1, 1'b0, 5, 4};
        tbl[8] = '{4'd0,  4'd0,  4'd15, 4'd0, 1'b1, 1, 0};
        tbl[9] = '{4'd1,  4'd1,  4'd1,  4'd0, 1'b0, 5, 4};

        // Reset state
        @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_quotient", int'(quotient), 0);
        check("reset_remainder", int'(remainder), 0);
        check("reset_div_by_zero", int'(div_by_zero), 0);
        check("reset_state", int'(dut.state_reg), int'(IDLE));
        rst_n = 1'b1;

        // Table vectors
        foreach (tbl[i]) begin
            run_one(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dbz,
                    tbl[i].lat, tbl[i].nbusy);
        end

        // start pulsed with 2/1 during the second RUN cycle of 13/4 is ignored
        @(posedge clk); #1;
        start = 1'b1; dividend = 4'd13; divisor = 4'd4;
        push(4'd13, 4'd4, 4'd3, 4'd1, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        fork
            begin
                repeat (2) @(negedge clk);
                start = 1'b1; dividend = 4'd2; divisor = 4'd1;
                @(posedge clk); #1;
                start = 1'b0;
            end
        join_none
        wait_done(5, 4);
        @(negedge clk);
        check("ignored_start_done_pulse", int'(done), 0);

        // Reset mid-run: outputs cleared at once, no done, restart on first edge
        @(posedge clk); #1;
        start = 1'b1; dividend = 4'd13; divisor = 4'd4;
        push(4'd13, 4'd4, 4'd3, 4'd1, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("run_busy_before_reset", int'(busy), 1);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("async_reset_busy", int'(busy), 0);
        check("async_reset_done", int'(done), 0);
        check("async_reset_quotient", int'(quotient), 0);
        check("async_reset_remainder", int'(remainder), 0);
        check("async_reset_div_by_zero", int'(div_by_zero), 0);
        check("async_reset_state", int'(dut.state_reg), int'(IDLE));
        check("async_reset_counter", int'(dut.cnt_reg), 0);
        repeat (3) begin
            @(negedge clk);
            check("no_done_in_reset", int'(done), 0);
        end
        start = 1'b1; dividend = 4'd6; divisor = 4'd4;
        push(4'd6, 4'd4, 4'd1, 4'd2, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(5, 4);
        @(negedge clk);
        check("post_reset_done_pulse", int'(done), 0);

        // start held through the done cycle: 13/4 then 12/5 back to back
        @(posedge clk); #1;
        start = 1'b1; dividend = 4'd13; divisor = 4'd4;
        push(4'd13, 4'd4, 4'd3, 4'd1, 1'b0);
        @(posedge clk); #1;
        dividend = 4'd12; divisor = 4'd5;
        push(4'd12, 4'd5, 4'd2, 4'd2, 1'b0);
        fork
            begin
                repeat (5) @(posedge clk);
                #1;
                start = 1'b0;
            end
        join_none
        wait_done(5, 4);
        wait_done(5, 4);
        @(negedge clk);
        check("b2b_done_pulse", int'(done), 0);

        // Random operands with nonzero divisor against the / % model
        for (int k = 0; k < 16; k++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            exp_t e;
            a = W'($urandom_range(0, 15));
            b = W'($urandom_range(1, 15));
            e = model(a, b);
            run_one(a, b, e.q, e.r, e.dbz, 5, 4);
        end

        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
